// File: rtl/escalator_multi_ctrl_pkg.sv
// Shared types and helpers for the multi-channel escalator controller.
// Holds the per-channel state encoding, the direction constants and the
// saturating speed-step helper used by every channel.
package esc_pkg;

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    ACCEL = 3'd1,
    RUN   = 3'd2,
    SLOW  = 3'd3,
    DECEL = 3'd4
  } esc_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Move a speed value one step up or down, clamping at 0 and maxVal.
  function automatic int unsigned satStep(input int unsigned val,
                                          input logic        up,
                                          input int unsigned maxVal);
    if (up) begin
      return (val >= maxVal) ? maxVal : val + 1;
    end
    return (val == 0) ? 0 : val - 1;
  endfunction

endpackage

// File: rtl/escalator_multi_ctrl_if.sv
// Sensor/enable inputs and motor outputs of the escalator controller.
// The estop line only exists when ESC_ESTOP_EN is defined.
interface escalator_multi_ctrl_if #(
  parameter int N_CH  = 2,
  parameter int SPD_W = 3
);

  logic                    i_tick;
  logic [N_CH-1:0]         i_enable;
  logic [N_CH-1:0]         i_presence;
  logic [N_CH-1:0]         i_dirReq;
`ifdef ESC_ESTOP_EN
  logic                    i_estop;
`endif
  logic [N_CH*SPD_W-1:0]   o_speed;
  logic [N_CH-1:0]         o_dir;
  logic [N_CH-1:0]         o_moving;

  modport master (
`ifdef ESC_ESTOP_EN
    output i_estop,
`endif
    output i_tick, i_enable, i_presence, i_dirReq,
    input  o_speed, o_dir, o_moving
  );

  modport slave (
`ifdef ESC_ESTOP_EN
    input  i_estop,
`endif
    input  i_tick, i_enable, i_presence, i_dirReq,
    output o_speed, o_dir, o_moving
  );

endinterface

// File: rtl/escalator_multi_ctrl_channel.sv
// One escalator channel: speed FSM with ramp and idle counters.
// Direction is latched only in STOP, so a reversal always passes through
// zero speed. With ESC_ESTOP_EN defined, estop drops the channel straight
// into STOP without ramping.
module esc_channel
  import esc_pkg::*;
#(
  parameter int SPD_W    = 3,
  parameter int SLOW_SPD = 2,
  parameter int RAMP_CYC = 8,
  parameter int IDLE_CYC = 1000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_enable,
  input  logic             i_presence,
  input  logic             i_dirReq,
`ifdef ESC_ESTOP_EN
  input  logic             i_estop,
`endif
  output logic [SPD_W-1:0] o_speed,
  output logic             o_dir,
  output logic             o_moving
);

  localparam logic [SPD_W-1:0] SPD_MAX   = '1;
  localparam logic [SPD_W-1:0] SPD_SLOW  = SPD_W'(SLOW_SPD);
  localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);

  esc_state_t       r_state;
  logic [SPD_W-1:0] r_speed;
  logic             r_dir;
  logic             r_moving;
  logic [CNT_W-1:0] r_rampCnt;
  logic [CNT_W-1:0] r_idleCnt;

  logic [SPD_W-1:0] w_speedUp;
  logic [SPD_W-1:0] w_speedDn;
  logic [CNT_W-1:0] w_rampInc;
  logic [CNT_W-1:0] w_idleInc;
  logic             w_rampDone;
  logic             w_idleDone;
  logic             w_abort;

  assign w_speedUp  = SPD_W'(satStep(32'(r_speed), 1'b1, 32'(SPD_MAX)));
  assign w_speedDn  = SPD_W'(satStep(32'(r_speed), 1'b0, 32'(SPD_MAX)));
  assign w_rampInc  = (r_rampCnt == '1) ? r_rampCnt : r_rampCnt + 1'b1;
  assign w_idleInc  = (r_idleCnt == '1) ? r_idleCnt : r_idleCnt + 1'b1;
  assign w_rampDone = i_tick && (r_rampCnt == RAMP_LAST);
  assign w_idleDone = i_tick && (r_idleCnt == IDLE_LAST);
  assign w_abort    = !i_enable || (i_dirReq != r_dir);

  // Speed FSM; losing enable or a direction change always heads for DECEL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= STOP;
      r_speed   <= '0;
      r_dir     <= DIR_UP;
      r_moving  <= 1'b0;
      r_rampCnt <= '0;
      r_idleCnt <= '0;
    end
`ifdef ESC_ESTOP_EN
    else if (i_estop) begin
      r_state   <= STOP;
      r_speed   <= '0;
      r_moving  <= 1'b0;
      r_rampCnt <= '0;
      r_idleCnt <= '0;
    end
`endif
    else begin
      case (r_state)
        STOP: begin
          r_speed   <= '0;
          r_rampCnt <= '0;
          r_idleCnt <= '0;
          if (i_enable && i_presence) begin
            r_dir    <= i_dirReq;
            r_state  <= ACCEL;
            r_moving <= 1'b1;
          end
        end
        ACCEL: begin
          if (w_abort) begin
            r_state   <= DECEL;
            r_rampCnt <= '0;
            r_idleCnt <= '0;
          end else if (r_speed == SPD_MAX) begin
            r_state   <= RUN;
            r_rampCnt <= '0;
            r_idleCnt <= '0;
          end else if (i_tick) begin
            if (w_rampDone) begin
              r_speed   <= w_speedUp;
              r_rampCnt <= '0;
              if (w_speedUp == SPD_MAX) begin
                r_state   <= RUN;
                r_idleCnt <= '0;
              end
            end else begin
              r_rampCnt <= w_rampInc;
            end
          end
        end
        RUN: begin
          if (w_abort) begin
            r_state   <= DECEL;
            r_rampCnt <= '0;
            r_idleCnt <= '0;
          end else if (i_presence) begin
            r_idleCnt <= '0;
          end else if (w_idleDone) begin
            r_state   <= SLOW;
            r_idleCnt <= '0;
            r_rampCnt <= '0;
          end else if (i_tick) begin
            r_idleCnt <= w_idleInc;
          end
        end
        SLOW: begin
          if (w_abort) begin
            r_state   <= DECEL;
            r_rampCnt <= '0;
            r_idleCnt <= '0;
          end else if (i_presence) begin
            r_state   <= ACCEL;
            r_rampCnt <= '0;
            r_idleCnt <= '0;
          end else if (i_tick) begin
            if (r_speed > SPD_SLOW) begin
              if (w_rampDone) begin
                r_speed   <= w_speedDn;
                r_rampCnt <= '0;
              end else begin
                r_rampCnt <= w_rampInc;
              end
            end else begin
              r_rampCnt <= '0;
            end
            if (w_idleDone) begin
              r_state   <= DECEL;
              r_idleCnt <= '0;
              r_rampCnt <= '0;
            end else begin
              r_idleCnt <= w_idleInc;
            end
          end
        end
        DECEL: begin
          r_idleCnt <= '0;
          if (r_speed == '0) begin
            r_state   <= STOP;
            r_moving  <= 1'b0;
            r_rampCnt <= '0;
          end else if (i_tick) begin
            if (w_rampDone) begin
              r_speed   <= w_speedDn;
              r_rampCnt <= '0;
              if (w_speedDn == '0) begin
                r_state  <= STOP;
                r_moving <= 1'b0;
              end
            end else begin
              r_rampCnt <= w_rampInc;
            end
          end
        end
        default: begin
          r_state   <= STOP;
          r_speed   <= '0;
          r_moving  <= 1'b0;
          r_rampCnt <= '0;
          r_idleCnt <= '0;
        end
      endcase
    end
  end

  assign o_speed  = r_speed;
  assign o_dir    = r_dir;
  assign o_moving = r_moving;

endmodule

// File: rtl/escalator_multi_ctrl.sv
// Multi-channel escalator controller top: N_CH independent channels whose
// speed codes are packed channel i at bits [i*SPD_W +: SPD_W].
// Define ESC_ESTOP_EN to add the shared emergency-stop input.
module escalator_multi_ctrl
  import esc_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int SPD_W    = 3,
  parameter int SLOW_SPD = 2,
  parameter int RAMP_CYC = 8,
  parameter int IDLE_CYC = 1000,
  parameter int CNT_W    = 16
) (
  input logic                   clk,
  input logic                   rst,
  escalator_multi_ctrl_if.slave bus
);

  logic [N_CH*SPD_W-1:0] w_speed;
  logic [N_CH-1:0]       w_dir;
  logic [N_CH-1:0]       w_moving;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    esc_channel #(
      .SPD_W    (SPD_W),
      .SLOW_SPD (SLOW_SPD),
      .RAMP_CYC (RAMP_CYC),
      .IDLE_CYC (IDLE_CYC),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_tick     (bus.i_tick),
      .i_enable   (bus.i_enable[g]),
      .i_presence (bus.i_presence[g]),
      .i_dirReq   (bus.i_dirReq[g]),
`ifdef ESC_ESTOP_EN
      .i_estop    (bus.i_estop),
`endif
      .o_speed    (w_speed[g*SPD_W +: SPD_W]),
      .o_dir      (w_dir[g]),
      .o_moving   (w_moving[g])
    );
  end

  assign bus.o_speed  = w_speed;
  assign bus.o_dir    = w_dir;
  assign bus.o_moving = w_moving;

endmodule

// File: tb/tb_escalator_multi_ctrl.sv
// Directed-vector bench for escalator_multi_ctrl with N_CH=2, SPD_W=2,
// SLOW_SPD=1, RAMP_CYC=2, IDLE_CYC=4 and a tick every cycle.
// The estop sequence is built only when ESC_ESTOP_EN is defined.
module tb_escalator_multi_ctrl;
  import esc_pkg::*;

  typedef struct {
    logic [1:0] en;
    logic [1:0] pres;
    logic [1:0] dreq;
    logic [3:0] expSpeed;
    logic [1:0] expDir;
    logic [1:0] expMov;
  } vec_t;

  vec_t vecs[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nFails  = 0;

  escalator_multi_ctrl_if #(.N_CH(2), .SPD_W(2)) bus ();

  escalator_multi_ctrl #(
    .N_CH     (2),
    .SPD_W    (2),
    .SLOW_SPD (1),
    .RAMP_CYC (2),
    .IDLE_CYC (4),
    .CNT_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Queue cnt identical vectors for the table.
  task automatic addVec(input int cnt, input logic [1:0] en, input logic [1:0] pres,
                        input logic [1:0] dreq, input logic [3:0] spd,
                        input logic [1:0] dir, input logic [1:0] mov);
    vec_t v;
    v.en = en; v.pres = pres; v.dreq = dreq;
    v.expSpeed = spd; v.expDir = dir; v.expMov = mov;
    for (int k = 0; k < cnt; k++) vecs.push_back(v);
  endtask

  // Drive one cycle of inputs and sample 1 unit after the edge.
  task automatic applyStimulus(input logic [1:0] en, input logic [1:0] pres,
                               input logic [1:0] dreq);
    bus.i_enable   = en;
    bus.i_presence = pres;
    bus.i_dirReq   = dreq;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expSpeed,
                             input logic [1:0] expDir, input logic [1:0] expMov);
    nChecks++;
    if (bus.o_speed !== expSpeed) begin
      nFails++;
      $display("[TB] FAIL %s speed: got %b expected %b", name, bus.o_speed, expSpeed);
    end
    nChecks++;
    if (bus.o_dir !== expDir) begin
      nFails++;
      $display("[TB] FAIL %s dir: got %b expected %b", name, bus.o_dir, expDir);
    end
    nChecks++;
    if (bus.o_moving !== expMov) begin
      nFails++;
      $display("[TB] FAIL %s moving: got %b expected %b", name, bus.o_moving, expMov);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.i_enable = 2'b00; bus.i_presence = 2'b00; bus.i_dirReq = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4'b0000, 2'b00, 2'b00);
    rst = 1'b0;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    bus.i_tick = 1'b1;
`ifdef ESC_ESTOP_EN
    bus.i_estop = 1'b0;
`endif
    doReset();

    // Both channels launch (ch1 down), reset lands while speed = 2.
    applyStimulus(2'b11, 2'b11, {DIR_DOWN, DIR_UP});
    checkOutput("launch both", 4'b0000, 2'b10, 2'b11);
    repeat (4) applyStimulus(2'b11, 2'b00, {DIR_DOWN, DIR_UP});
    checkOutput("mid accel", 4'b1010, 2'b10, 2'b11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset mid-ACCEL", 4'b0000, 2'b00, 2'b00);
    rst = 1'b0;

    // Start-up down on ch0, idle slow-down, decel and stop.
    addVec(1, 2'b01, 2'b01, 2'b01, 4'd0, 2'b01, 2'b01);
    addVec(1, 2'b01, 2'b00, 2'b01, 4'd0, 2'b01, 2'b01);
    addVec(2, 2'b01, 2'b00, 2'b01, 4'd1, 2'b01, 2'b01);
    addVec(2, 2'b01, 2'b00, 2'b01, 4'd2, 2'b01, 2'b01);
    addVec(6, 2'b01, 2'b00, 2'b01, 4'd3, 2'b01, 2'b01);
    addVec(2, 2'b01, 2'b00, 2'b01, 4'd2, 2'b01, 2'b01);
    addVec(2, 2'b01, 2'b00, 2'b01, 4'd1, 2'b01, 2'b01);
    addVec(2, 2'b01, 2'b00, 2'b01, 4'd0, 2'b01, 2'b00);
    // Relaunch up, then reverse with presence held.
    addVec(2, 2'b01, 2'b01, 2'b00, 4'd0, 2'b00, 2'b01);
    addVec(2, 2'b01, 2'b01, 2'b00, 4'd1, 2'b00, 2'b01);
    addVec(2, 2'b01, 2'b01, 2'b00, 4'd2, 2'b00, 2'b01);
    addVec(1, 2'b01, 2'b01, 2'b00, 4'd3, 2'b00, 2'b01);
    addVec(2, 2'b01, 2'b01, 2'b01, 4'd3, 2'b00, 2'b01);
    addVec(2, 2'b01, 2'b01, 2'b01, 4'd2, 2'b00, 2'b01);
    addVec(2, 2'b01, 2'b01, 2'b01, 4'd1, 2'b00, 2'b01);
    addVec(1, 2'b01, 2'b01, 2'b01, 4'd0, 2'b00, 2'b00);
    addVec(2, 2'b01, 2'b01, 2'b01, 4'd0, 2'b01, 2'b01);
    addVec(1, 2'b01, 2'b01, 2'b01, 4'd1, 2'b01, 2'b01);
    // Back to RUN, into SLOW, then enable drop with presence high.
    addVec(1, 2'b01, 2'b00, 2'b01, 4'd1, 2'b01, 2'b01);
    addVec(2, 2'b01, 2'b00, 2'b01, 4'd2, 2'b01, 2'b01);
    addVec(6, 2'b01, 2'b00, 2'b01, 4'd3, 2'b01, 2'b01);
    addVec(2, 2'b00, 2'b01, 2'b01, 4'd3, 2'b01, 2'b01);
    addVec(2, 2'b00, 2'b01, 2'b01, 4'd2, 2'b01, 2'b01);
    addVec(2, 2'b00, 2'b01, 2'b01, 4'd1, 2'b01, 2'b01);
    addVec(3, 2'b00, 2'b01, 2'b01, 4'd0, 2'b01, 2'b00);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].pres, vecs[i].dreq);
      checkOutput($sformatf("vec%0d", i), vecs[i].expSpeed, vecs[i].expDir, vecs[i].expMov);
    end

`ifdef ESC_ESTOP_EN
    // Both channels up to full speed, estop, then release without presence.
    doReset();
    repeat (7) applyStimulus(2'b11, 2'b11, 2'b00);
    checkOutput("estop pre", 4'b1111, 2'b00, 2'b11);
    bus.i_estop = 1'b1;
    applyStimulus(2'b11, 2'b00, 2'b00);
    checkOutput("estop hit", 4'b0000, 2'b00, 2'b00);
    bus.i_estop = 1'b0;
    repeat (3) applyStimulus(2'b11, 2'b00, 2'b00);
    checkOutput("estop release", 4'b0000, 2'b00, 2'b00);
    applyStimulus(2'b11, 2'b11, 2'b00);
    checkOutput("estop relaunch", 4'b0000, 2'b00, 2'b11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
